// File: rtl/dcs_pkg.sv
// Shared constants, state encoding and data typedefs for the DCSformer
// host-side stream driver.
package dcs_pkg;

  localparam int ROWS      = 8;    // matrix rows, weight count, result count
  localparam int COLS      = 16;   // matrix columns
  localparam int DW        = 8;    // input / weight byte width
  localparam int OW        = 32;   // result word width
  localparam int MAT_BYTES = ROWS * COLS;
  localparam int W_BASE    = MAT_BYTES;      // weights follow the matrix
  localparam int BUF_DEPTH = MAT_BYTES + ROWS;

  typedef logic [DW-1:0] byte_t;
  typedef logic [OW-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND_I,
    WAIT_W,
    SEND_W,
    COLLECT
  } state_t;

endpackage

// File: rtl/dcs_stream_driver_if.sv
// Core-facing stream bundle between the driver (master) and the attention
// core (slave).
//   i_valid/i_data : matrix bytes, driver -> core
//   w_ready        : core asks for weights (one-cycle pulse)
//   w_valid/w_data : weight bytes, driver -> core
//   o_valid/o_data : result words, core -> driver
interface dcs_stream_driver_if;
  import dcs_pkg::*;

  logic  i_valid;
  byte_t i_data;
  logic  w_ready;
  logic  w_valid;
  byte_t w_data;
  logic  o_valid;
  word_t o_data;

  modport master (
    output i_valid, i_data, w_valid, w_data,
    input  w_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, w_valid, w_data,
    output w_ready, o_valid, o_data
  );

endinterface

// File: rtl/dcs_byte_buf.sv
// Job buffer: 128 matrix bytes followed by 8 weight bytes.
// One synchronous write port, one combinational read port. Not reset.
//   clk   : clock
//   we    : write strobe
//   waddr : write address (out-of-range writes dropped)
//   wdata : write data
//   raddr : read address (out-of-range reads return 0)
//   rdata : read data
module dcs_byte_buf
  import dcs_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  byte_t      wdata,
  input  logic [7:0] raddr,
  output byte_t      rdata
);

  byte_t mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < 8'(BUF_DEPTH))) mem[waddr] <= wdata;
  end

  assign rdata = (raddr < 8'(BUF_DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/dcs_stream_driver.sv
// Host-side initiator for the DCSformer attention core. Streams the buffered
// 8x16 matrix, waits for w_ready, streams 8 weights, then captures 8 results.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_we/addr/wdata  : buffer load (IDLE only)
//   start              : launch a job from IDLE
//   busy, done, err    : status; done/err are one-cycle pulses
//   core               : stream bundle to the core (master side)
//   res_addr/res_data  : combinational result readback
module dcs_stream_driver
  import dcs_pkg::*;
#(
  parameter int TMO = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [7:0]                 cfg_addr,
  input  byte_t                      cfg_wdata,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  dcs_stream_driver_if.master        core,
  input  logic [2:0]                 res_addr,
  output word_t                      res_data
);

  localparam int TW = $clog2(TMO + 1);

  state_t        state;
  logic [6:0]    idx;        // beat index within the current phase
  logic [TW-1:0] tmo_cnt;
  logic          wr_seen;    // w_ready arrived while the matrix was streaming
  word_t         result [ROWS];

  logic [7:0]    rd_addr;
  byte_t         buf_rdata;
  byte_t         rd_byte;

  dcs_byte_buf u_buf (
    .clk   (clk),
    .we    (cfg_we && (state == IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd_addr),
    .rdata (buf_rdata)
  );

  // Read address always points at the byte to be registered on the next edge.
  always_comb begin
    rd_addr = '0;
    case (state)
      IDLE:    rd_addr = '0;
      SEND_I:  rd_addr = (idx == 7'(MAT_BYTES - 1)) ? 8'(W_BASE) : ({1'b0, idx} + 8'd1);
      WAIT_W:  rd_addr = 8'(W_BASE);
      SEND_W:  rd_addr = 8'(W_BASE) + {5'b0, idx[2:0]} + 8'd1;
      default: rd_addr = '0;
    endcase
  end

  // A write landing on the same edge as start must reach the first beat.
  assign rd_byte = ((state == IDLE) && cfg_we && (cfg_addr == rd_addr)) ? cfg_wdata : buf_rdata;

  assign busy     = (state != IDLE);
  assign res_data = result[res_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      tmo_cnt      <= '0;
      wr_seen      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      core.i_valid <= 1'b0;
      core.i_data  <= '0;
      core.w_valid <= 1'b0;
      core.w_data  <= '0;
      for (int i = 0; i < ROWS; i++) result[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND_I;
            idx          <= '0;
            wr_seen      <= 1'b0;
            core.i_valid <= 1'b1;
            core.i_data  <= rd_byte;
            for (int i = 0; i < ROWS; i++) result[i] <= '0;
          end
        end
        SEND_I: begin
          if (core.w_ready) wr_seen <= 1'b1;
          if (idx == 7'(MAT_BYTES - 1)) begin
            core.i_valid <= 1'b0;
            core.i_data  <= '0;
            idx          <= '0;
            tmo_cnt      <= '0;
            if (wr_seen || core.w_ready) begin
              state        <= SEND_W;
              core.w_valid <= 1'b1;
              core.w_data  <= rd_byte;
            end else begin
              state <= WAIT_W;
            end
          end else begin
            idx         <= idx + 7'd1;
            core.i_data <= rd_byte;
          end
        end
        WAIT_W: begin
          if (core.w_ready) begin
            state        <= SEND_W;
            idx          <= '0;
            core.w_valid <= 1'b1;
            core.w_data  <= rd_byte;
          end else if (tmo_cnt == TW'(TMO - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEND_W: begin
          if (idx == 7'(ROWS - 1)) begin
            core.w_valid <= 1'b0;
            core.w_data  <= '0;
            idx          <= '0;
            tmo_cnt      <= '0;
            state        <= COLLECT;
          end else begin
            idx         <= idx + 7'd1;
            core.w_data <= rd_byte;
          end
        end
        COLLECT: begin
          if (core.o_valid) begin
            result[idx[2:0]] <= core.o_data;
            tmo_cnt          <= '0;
            if (idx == 7'(ROWS - 1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx <= idx + 7'd1;
            end
          end else if (tmo_cnt == TW'(TMO - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcs_stream_driver.sv
// Scoreboard bench for dcs_stream_driver: stimulus pushes expected stream
// bytes into queues, a negedge monitor pops and compares each emitted beat.
module tb_dcs_stream_driver;
  import dcs_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [2:0]  res_addr = '0;
  logic [31:0] res_data;

  dcs_stream_driver_if ifc ();

  dcs_stream_driver #(.TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .core      (ifc),
    .res_addr  (res_addr),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mat [128];
  logic [7:0] wts [8];
  logic [7:0] exp_i [$];
  logic [7:0] exp_w [$];

  int nvec = 0;
  int nfail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  int   i_cnt = 0, i_first = 0, i_last = 0;
  int   w_cnt = 0, w_first = 0, w_last = 0;
  int   done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  logic i_prev = 1'b0, w_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.i_valid) begin
        if (!i_prev) i_first = cyc;
        i_last = cyc;
        i_cnt++;
        if (exp_i.size() == 0) check("i_extra_beat", 1, 0);
        else check("i_data", ifc.i_data, exp_i.pop_front());
      end
      if (ifc.w_valid) begin
        if (!w_prev) w_first = cyc;
        w_last = cyc;
        w_cnt++;
        if (exp_w.size() == 0) check("w_extra_beat", 1, 0);
        else check("w_data", ifc.w_data, exp_w.pop_front());
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err)  begin err_cnt++;  err_cyc  = cyc; end
    end
    i_prev = ifc.i_valid;
    w_prev = ifc.w_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic launch(input bit wr0, input logic [7:0] d0, output int s);
    if (wr0) mat[0] = d0;
    for (int a = 0; a < 128; a++) exp_i.push_back(mat[a]);
    for (int k = 0; k < 8; k++) exp_w.push_back(wts[k]);
    start = 1'b1;
    if (wr0) begin cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = d0; end
    s = cyc;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_w(input int target);
    int n = 0;
    while (w_cnt < target && n < 400) begin @(negedge clk); n++; end
    check("w_stream_arrived", (w_cnt >= target), 1);
  endtask

  // wmode 0: w_ready 20 cycles after start (during SEND_I); 1: 5 cycles into WAIT_W
  task automatic run_job(input int wmode, input int gap, input int base,
                         input bit wr0, input logic [7:0] d0, input bit poke);
    int s, i0, w0, d_0, e0, rcyc, last;
    i0 = i_cnt; w0 = w_cnt; d_0 = done_cnt; e0 = err_cnt;
    launch(wr0, d0, s);
    if (poke) begin
      wait_cyc(s + 40);
      start = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 8'hFF;
      tick();
      start = 1'b0; cfg_we = 1'b0;
    end
    wait_cyc((wmode == 0) ? s + 20 : s + 133);
    ifc.w_ready = 1'b1; rcyc = cyc;
    tick();
    ifc.w_ready = 1'b0;
    wait_w(w0 + 8);
    check("i_count", i_cnt - i0, 128);
    check("i_first", i_first, s + 1);
    check("i_last", i_last, s + 128);
    check("w_first", w_first, (wmode == 0) ? s + 129 : rcyc + 1);
    check("w_count", w_cnt - w0, 8);
    check("w_span", w_last - w_first, 7);
    // model core returns base*(k+1)
    @(posedge clk); #1;
    last = cyc;
    for (int k = 0; k < 8; k++) begin
      ifc.o_valid = 1'b1; ifc.o_data = 32'(base * (k + 1)); last = cyc;
      tick();
      ifc.o_valid = 1'b0;
      repeat (gap) tick();
    end
    tick();
    check("busy_after_done", busy, 0);
    tick();
    check("done_pulses", done_cnt - d_0, 1);
    check("done_cycle", done_cyc, last + 1);
    check("err_pulses", err_cnt - e0, 0);
    for (int a = 0; a < 8; a++) begin
      res_addr = 3'(a); #1;
      check("res_data", res_data, base * (a + 1));
    end
    check("i_queue_drained", exp_i.size(), 0);
    check("w_queue_drained", exp_w.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e0, w0, n;
    ifc.w_ready = 1'b0; ifc.o_valid = 1'b0; ifc.o_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_i_valid", ifc.i_valid, 0);
    check("rst_i_data", ifc.i_data, 0);
    check("rst_w_valid", ifc.w_valid, 0);
    check("rst_w_data", ifc.w_data, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 128; a++) begin mat[a] = 8'(a); cfg_write(8'(a), 8'(a)); end
    for (int k = 0; k < 8; k++) begin wts[k] = 8'(k + 1); cfg_write(8'(128 + k), 8'(k + 1)); end
    cfg_write(8'd200, 8'h77);  // out of range, dropped

    // A: w_ready during SEND_I, back-to-back results
    run_job(0, 0, 100, 1'b0, 8'h00, 1'b0);

    // Timeout in WAIT_W; results cleared on job start
    e0 = err_cnt; w0 = w_cnt;
    launch(1'b0, 8'h00, s);
    n = 0;
    while (err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
    check("tmo_err_seen", err_cnt - e0, 1);
    check("tmo_err_cycle", err_cyc, s + 145);
    check("tmo_no_weights", w_cnt - w0, 0);
    tick();
    check("tmo_busy", busy, 0);
    res_addr = 3'd2; #1;
    check("tmo_res_cleared", res_data, 0);
    check("tmo_i_drained", exp_i.size(), 0);
    exp_w.delete();

    // B: w_ready in WAIT_W, results every 3 cycles
    run_job(1, 2, 11, 1'b0, 8'h00, 1'b0);

    // reset in IDLE clears results
    rst = 1'b1; tick(); rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      res_addr = 3'(a); #1;
      check("idle_rst_res", res_data, 0);
    end
    tick();

    // D: start + cfg_we mid-stream are ignored; E: byte 0 still original
    run_job(1, 0, 7, 1'b0, 8'h00, 1'b1);
    run_job(0, 0, 3, 1'b0, 8'h00, 1'b0);

    // F: write together with start is used by the job
    run_job(1, 1, 5, 1'b1, 8'h5A, 1'b0);

    // G: reset during weight beat 4
    w0 = w_cnt;
    launch(1'b0, 8'h00, s);
    wait_cyc(s + 20);
    ifc.w_ready = 1'b1; tick(); ifc.w_ready = 1'b0;
    wait_cyc(s + 133);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_w_valid", ifc.w_valid, 0);
    check("midrst_busy", busy, 0);
    res_addr = 3'd0; #1;
    check("midrst_res_data", res_data, 0);
    check("midrst_w_beats", w_cnt - w0, 4);
    exp_i.delete();
    exp_w.delete();
    tick();

    // H: fresh job after reset
    run_job(0, 0, 9, 1'b0, 8'h00, 1'b0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
